// File: rtl/exe_stage_pkg.sv
// Shared widths, bus layouts and ALU op indices for the execute stage.
// ES_FW_DATA_EN selects the wide (data-forwarding) hazard bus.
package exe_stage_pkg;

    localparam int unsigned DS_TO_ES_BUS_WD = 148;
    localparam int unsigned ES_TO_MS_BUS_WD = 71;
`ifdef ES_FW_DATA_EN
    localparam int unsigned ES_FW_BUS_WD = 39;
`else
    localparam int unsigned ES_FW_BUS_WD = 6;
`endif
    localparam int unsigned ALU_OP_WD = 12;

    // Bit positions inside the one-hot alu_op field
    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpSlt  = 4'd2,
        OpSltu = 4'd3,
        OpAnd  = 4'd4,
        OpNor  = 4'd5,
        OpOr   = 4'd6,
        OpXor  = 4'd7,
        OpSll  = 4'd8,
        OpSrl  = 4'd9,
        OpSra  = 4'd10,
        OpLui  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 res_from_mem;
        logic                 gr_we;
        logic                 mem_we;
        logic [ALU_OP_WD-1:0] alu_op;
        logic [4:0]           dest;
        logic [31:0]          alu_src1;
        logic [31:0]          alu_src2;
        logic [31:0]          rkd_value;
    } ds_to_es_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
    } es_to_ms_t;

    function automatic logic [ALU_OP_WD-1:0] alu_onehot(alu_op_e op);
        return 12'(1) << op;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX/MEM handshake, pipeline buses, data-SRAM request and hazard bus.
// master: the execute stage; slave: its surroundings (ID, MEM, SRAM).
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_we;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;
    logic [ES_FW_BUS_WD-1:0]    es_fw_bus;

    modport master (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_bus,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, es_fw_bus
    );

    modport slave (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, es_fw_bus
    );

endinterface

// File: rtl/exe_stage_alu.sv
// Combinational 12-operation ALU with one-hot op select.
// Each result is gated by its op bit, so an all-zero op yields zero.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] i_alu_op,
    input  logic [31:0]          i_alu_src1,
    input  logic [31:0]          i_alu_src2,
    output logic [31:0]          o_alu_result
);

    logic [4:0]  w_shamt;
    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sra;

    always_comb begin
        w_shamt = i_alu_src2[4:0];
        w_add   = i_alu_src1 + i_alu_src2;
        w_sub   = i_alu_src1 - i_alu_src2;
        w_slt   = {31'b0, $signed(i_alu_src1) < $signed(i_alu_src2)};
        w_sltu  = {31'b0, i_alu_src1 < i_alu_src2};
        w_sra   = $unsigned($signed(i_alu_src1) >>> w_shamt);

        o_alu_result = ({32{i_alu_op[OpAdd]}}  & w_add)
                     | ({32{i_alu_op[OpSub]}}  & w_sub)
                     | ({32{i_alu_op[OpSlt]}}  & w_slt)
                     | ({32{i_alu_op[OpSltu]}} & w_sltu)
                     | ({32{i_alu_op[OpAnd]}}  & (i_alu_src1 & i_alu_src2))
                     | ({32{i_alu_op[OpNor]}}  & ~(i_alu_src1 | i_alu_src2))
                     | ({32{i_alu_op[OpOr]}}   & (i_alu_src1 | i_alu_src2))
                     | ({32{i_alu_op[OpXor]}}  & (i_alu_src1 ^ i_alu_src2))
                     | ({32{i_alu_op[OpSll]}}  & (i_alu_src1 << w_shamt))
                     | ({32{i_alu_op[OpSrl]}}  & (i_alu_src1 >> w_shamt))
                     | ({32{i_alu_op[OpSra]}}  & w_sra)
                     | ({32{i_alu_op[OpLui]}}  & i_alu_src2);
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID->EX pipeline register, ALU, data-SRAM request and hazard bus to ID.
// Build option ES_FW_DATA_EN widens the hazard bus to carry the ALU result for bypassing.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    exe_stage_if.master  es_if
);

    logic        r_es_valid;
    ds_to_es_t   r_bus;
    logic        w_es_ready_go;
    logic        w_es_allowin;
    logic        w_vwe;
    logic [31:0] w_alu_result;
    es_to_ms_t   w_to_ms;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (w_es_allowin) begin
            r_es_valid <= es_if.ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= '0;
        end else if (w_es_allowin && es_if.ds_to_es_valid) begin
            r_bus <= ds_to_es_t'(es_if.ds_to_es_bus);
        end
    end

    exe_stage_alu u_alu (
        .i_alu_op     (r_bus.alu_op),
        .i_alu_src1   (r_bus.alu_src1),
        .i_alu_src2   (r_bus.alu_src2),
        .o_alu_result (w_alu_result)
    );

    always_comb begin
        w_es_ready_go = 1'b1;
        w_es_allowin  = ~r_es_valid | (w_es_ready_go & es_if.ms_allowin);
        w_vwe         = r_es_valid & r_bus.gr_we;

        w_to_ms.pc           = r_bus.pc;
        w_to_ms.res_from_mem = r_bus.res_from_mem;
        w_to_ms.gr_we        = r_bus.gr_we;
        w_to_ms.dest         = r_bus.dest;
        w_to_ms.alu_result   = w_alu_result;
    end

    assign es_if.es_allowin     = w_es_allowin;
    assign es_if.es_to_ms_valid = r_es_valid & w_es_ready_go;
    assign es_if.es_to_ms_bus   = w_to_ms;

    // Request only in the hand-off cycle: one write per store, read data lands as MEM latches
    assign es_if.data_sram_en    = r_es_valid & es_if.ms_allowin;
    assign es_if.data_sram_we    = {4{r_bus.mem_we & r_es_valid & es_if.ms_allowin}};
    assign es_if.data_sram_addr  = w_alu_result;
    assign es_if.data_sram_wdata = r_bus.rkd_value;

`ifdef ES_FW_DATA_EN
    assign es_if.es_fw_bus = {w_vwe, r_bus.res_from_mem & r_es_valid, r_bus.dest, w_alu_result};
`else
    assign es_if.es_fw_bus = {w_vwe, r_bus.dest};
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; expected values are hand-computed.
// Follows the ES_FW_DATA_EN build option for the hazard-bus expectations.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    exe_stage_if u_if ();

    exe_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .es_if (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int N_ALU = 14;
    localparam logic [11:0] T_OP [N_ALU] = '{
        12'h001, 12'h004, 12'h008, 12'h400, 12'h002, 12'h004, 12'h010,
        12'h020, 12'h040, 12'h080, 12'h100, 12'h200, 12'h800, 12'h000};
    localparam logic [31:0] T_S1 [N_ALU] = '{
        32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
        32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
        32'h00000001, 32'h80000000, 32'h00000000, 32'h00000005};
    localparam logic [31:0] T_S2 [N_ALU] = '{
        32'h00000001, 32'h00000001, 32'h00000001, 32'h00000004, 32'h00000001,
        32'h00000001, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
        32'h00000021, 32'h00000004, 32'hABCDE000, 32'h00000005};
    localparam logic [31:0] T_EXP [N_ALU] = '{
        32'h80000000, 32'h00000000, 32'h00000000, 32'hF8000000, 32'hFFFFFFFF,
        32'h00000001, 32'hF000F000, 32'h000F000F, 32'hFFF0FFF0, 32'h0FF00FF0,
        32'h00000002, 32'h08000000, 32'hABCDE000, 32'h00000000};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input ds_to_es_t b);
        u_if.ds_to_es_valid = v;
        u_if.ds_to_es_bus   = b;
    endtask

    function automatic ds_to_es_t mk(input logic [31:0] pc, input logic rfm, input logic gr_we,
                                     input logic mem_we, input logic [11:0] op,
                                     input logic [4:0] dest, input logic [31:0] s1,
                                     input logic [31:0] s2, input logic [31:0] rkd);
        ds_to_es_t b;
        b.pc = pc; b.res_from_mem = rfm; b.gr_we = gr_we; b.mem_we = mem_we;
        b.alu_op = op; b.dest = dest; b.alu_src1 = s1; b.alu_src2 = s2; b.rkd_value = rkd;
        return b;
    endfunction

    function automatic logic [127:0] exp_fw(input logic vwe, input logic ld, input logic [4:0] dest,
                                            input logic [31:0] res);
`ifdef ES_FW_DATA_EN
        return 128'({vwe, ld, dest, res});
`else
        return 128'({vwe, dest});
`endif
    endfunction

    function automatic logic [127:0] exp_ms(input logic [31:0] pc, input logic rfm,
                                            input logic gr_we, input logic [4:0] dest,
                                            input logic [31:0] res);
        return 128'({pc, rfm, gr_we, dest, res});
    endfunction

    ds_to_es_t st_b;
    ds_to_es_t bl_b;
    ds_to_es_t ld_b;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        u_if.ms_allowin = 1'b1;
        drive(1'b0, '0);

        // Reset state
        repeat (2) tick();
        sample();
        check("rst_valid",   128'(u_if.es_to_ms_valid), 128'(1'b0));
        check("rst_allowin", 128'(u_if.es_allowin), 128'(1'b1));
        check("rst_en",      128'(u_if.data_sram_en), 128'(1'b0));
        check("rst_we",      128'(u_if.data_sram_we), 128'(4'h0));
        check("rst_fw",      128'(u_if.es_fw_bus), 128'(0));

        // ALU ops back-to-back, one per cycle
        tick();
        reset = 1'b0;
        drive(1'b1, mk(32'd0, 1'b0, 1'b1, 1'b0, T_OP[0], 5'd0, T_S1[0], T_S2[0], 32'h0));
        for (int i = 0; i < N_ALU; i++) begin
            tick();
            if (i + 1 < N_ALU)
                drive(1'b1, mk(32'(i + 1), 1'b0, 1'b1, 1'b0, T_OP[i+1], 5'(i + 1),
                               T_S1[i+1], T_S2[i+1], 32'h0));
            else
                drive(1'b0, '0);
            sample();
            check($sformatf("alu%0d_ms_bus", i), 128'(u_if.es_to_ms_bus),
                  exp_ms(32'(i), 1'b0, 1'b1, 5'(i), T_EXP[i]));
            check($sformatf("alu%0d_valid", i), 128'(u_if.es_to_ms_valid), 128'(1'b1));
            check($sformatf("alu%0d_allowin", i), 128'(u_if.es_allowin), 128'(1'b1));
            if (i == 0)
                check("add_fw", 128'(u_if.es_fw_bus), exp_fw(1'b1, 1'b0, 5'd0, 32'h80000000));
        end

        // Bubble
        tick();
        sample();
        check("bubble_valid", 128'(u_if.es_to_ms_valid), 128'(1'b0));
        check("bubble_en",    128'(u_if.data_sram_en), 128'(1'b0));

        // Store under 3 cycles of back-pressure; bl waits in ID and enters on release
        st_b = mk(32'h300, 1'b0, 1'b0, 1'b1, alu_onehot(OpAdd), 5'd0,
                  32'h1000, 32'h8, 32'hDEADBEEF);
        bl_b = mk(32'h1C000000, 1'b0, 1'b1, 1'b0, alu_onehot(OpAdd), 5'd1,
                  32'h1C000000, 32'h4, 32'h0);
        u_if.ms_allowin = 1'b0;
        drive(1'b1, st_b);
        tick();
        drive(1'b1, bl_b);
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("stall%0d_valid", c), 128'(u_if.es_to_ms_valid), 128'(1'b1));
            check($sformatf("stall%0d_allowin", c), 128'(u_if.es_allowin), 128'(1'b0));
            check($sformatf("stall%0d_en", c), 128'(u_if.data_sram_en), 128'(1'b0));
            check($sformatf("stall%0d_we", c), 128'(u_if.data_sram_we), 128'(4'h0));
            check($sformatf("stall%0d_addr", c), 128'(u_if.data_sram_addr), 128'(32'h1008));
            tick();
        end
        u_if.ms_allowin = 1'b1;
        sample();
        check("st_we",      128'(u_if.data_sram_we), 128'(4'hF));
        check("st_en",      128'(u_if.data_sram_en), 128'(1'b1));
        check("st_addr",    128'(u_if.data_sram_addr), 128'(32'h1008));
        check("st_wdata",   128'(u_if.data_sram_wdata), 128'(32'hDEADBEEF));
        check("st_allowin", 128'(u_if.es_allowin), 128'(1'b1));

        // bl replaces the store in the same edge
        tick();
        drive(1'b0, '0);
        sample();
        check("bl_ms_bus", 128'(u_if.es_to_ms_bus),
              exp_ms(32'h1C000000, 1'b0, 1'b1, 5'd1, 32'h1C000004));
        check("bl_fw",     128'(u_if.es_fw_bus), exp_fw(1'b1, 1'b0, 5'd1, 32'h1C000004));
        check("bl_we",     128'(u_if.data_sram_we), 128'(4'h0));

        // Load to r5 enters as bl leaves, then stalls
        ld_b = mk(32'h200, 1'b1, 1'b1, 1'b0, alu_onehot(OpAdd), 5'd5, 32'h40, 32'h0, 32'h0);
        drive(1'b1, ld_b);
        tick();
        u_if.ms_allowin = 1'b0;
        drive(1'b0, '0);
        sample();
        check("ld_fw",     128'(u_if.es_fw_bus), exp_fw(1'b1, 1'b1, 5'd5, 32'h40));
        check("ld_ms_bus", 128'(u_if.es_to_ms_bus), exp_ms(32'h200, 1'b1, 1'b1, 5'd5, 32'h40));
        check("ld_en",     128'(u_if.data_sram_en), 128'(1'b0));

        // Reset mid-stall, with ID offering a new instruction
        tick();
        reset = 1'b1;
        drive(1'b1, bl_b);
        tick();
        reset = 1'b0;
        drive(1'b0, '0);
        sample();
        check("rst2_valid",   128'(u_if.es_to_ms_valid), 128'(1'b0));
        check("rst2_en",      128'(u_if.data_sram_en), 128'(1'b0));
        check("rst2_fw",      128'(u_if.es_fw_bus), 128'(0));
        check("rst2_allowin", 128'(u_if.es_allowin), 128'(1'b1));
        check("rst2_ms_bus",  128'(u_if.es_to_ms_bus), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
